// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regs
// Purpose  : I2C target that decodes START/STOP, matches a 7-bit address and
//            maps bus transfers onto a register port. The first written byte
//            after the address sets the register pointer. The following bytes
//            are written, or read, with the pointer auto-incremented.
// Ports    : clk        - system clock (much faster than SCL)
//            reset      - asynchronous active-low reset
//            scl        - I2C clock from the master (no clock stretching)
//            sda        - I2C data, open-drain (driven 0 or released)
//            reg_addr   - current register pointer
//            reg_wdata  - write data, valid while reg_we is high
//            reg_we     - one-clk write strobe
//            reg_rdata  - combinational read data for reg_addr
//            busy       - high from address match to STOP/mismatch/NACK
//            stop_det   - one-clk pulse on every STOP
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42,
   parameter int         NUM_REGS   = 16,
   parameter int         ADDR_W     = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl,
   inout  wire               sda,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              stop_det
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      PTR       = 4'd3,
      WDATA     = 4'd4,
      W_ACK     = 4'd5,
      RDATA     = 4'd6,
      R_ACK     = 4'd7,
      WAIT_STOP = 4'd8
   } state_t;

   state_t      state;
   logic        scl_s1, scl_s2, scl_prev;
   logic        sda_s1, sda_s2, sda_prev;
   logic [7:0]  shift;
   logic [2:0]  bit_cnt;
   logic        byte_done;
   logic        rw;
   logic        drive_low;

   logic        scl_rise, scl_fall, start_cond, stop_cond, addr_match;

   assign sda = drive_low ? 1'b0 : 1'bz;

   // Synchronizers reset to 1 (idle bus level) so no false edge follows reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_s1   <= 1'b1;
         scl_s2   <= 1'b1;
         scl_prev <= 1'b1;
         sda_s1   <= 1'b1;
         sda_s2   <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_s1   <= scl;
         scl_s2   <= scl_s1;
         scl_prev <= scl_s2;
         sda_s1   <= sda;
         sda_s2   <= sda_s1;
         sda_prev <= sda_s2;
      end
   end

   assign scl_rise   =  scl_s2 & ~scl_prev;
   assign scl_fall   = ~scl_s2 &  scl_prev;
   assign start_cond =  scl_s2 &  scl_prev &  sda_prev & ~sda_s2;
   assign stop_cond  =  scl_s2 &  scl_prev & ~sda_prev &  sda_s2;
   assign addr_match = (shift[7:1] == SLAVE_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shift     <= 8'h00;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         rw        <= 1'b0;
         drive_low <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         reg_we   <= 1'b0;
         stop_det <= 1'b0;
         // Pointer advances the clock after a write strobe (natural wrap).
         if (reg_we)
            reg_addr <= reg_addr + 1'b1;

         if (start_cond) begin
            // Also aborts any partial byte: no strobe, pointer untouched.
            state     <= ADDR;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            drive_low <= 1'b0;
         end else if (stop_cond) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            stop_det  <= 1'b1;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise && !byte_done) begin
                     shift   <= {shift[6:0], sda_s2};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        byte_done <= 1'b1;
                  end else if (scl_fall && byte_done) begin
                     // The fall after the 8th sample opens the ACK slot.
                     byte_done <= 1'b0;
                     bit_cnt   <= 3'd0;
                     if (state == ADDR) begin
                        if (addr_match) begin
                           drive_low <= 1'b1;
                           busy      <= 1'b1;
                           rw        <= shift[0];
                           state     <= ADDR_ACK;
                        end else begin
                           busy  <= 1'b0;
                           state <= WAIT_STOP;
                        end
                     end else if (state == PTR) begin
                        reg_addr  <= shift[ADDR_W-1:0];
                        drive_low <= 1'b1;
                        state     <= W_ACK;
                     end else begin
                        reg_wdata <= shift;
                        reg_we    <= 1'b1;
                        drive_low <= 1'b1;
                        state     <= W_ACK;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (rw) begin
                        shift     <= reg_rdata;
                        drive_low <= ~reg_rdata[7];
                        state     <= RDATA;
                     end else begin
                        drive_low <= 1'b0;
                        state     <= PTR;
                     end
                  end
               end
               W_ACK: begin
                  if (scl_fall) begin
                     drive_low <= 1'b0;
                     state     <= WDATA;
                  end
               end
               RDATA: begin
                  if (scl_rise && !byte_done) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        byte_done <= 1'b1;
                  end else if (scl_fall) begin
                     if (byte_done) begin
                        // Release for the master's ACK/NACK bit.
                        byte_done <= 1'b0;
                        bit_cnt   <= 3'd0;
                        drive_low <= 1'b0;
                        state     <= R_ACK;
                     end else begin
                        shift     <= {shift[6:0], 1'b0};
                        drive_low <= ~shift[6];
                     end
                  end
               end
               R_ACK: begin
                  // Any fall seen here follows an ACK; NACK leaves the state on the rise.
                  if (scl_rise) begin
                     if (sda_s2) begin
                        busy  <= 1'b0;
                        state <= WAIT_STOP;
                     end else begin
                        reg_addr <= reg_addr + 1'b1;
                     end
                  end else if (scl_fall) begin
                     shift     <= reg_rdata;
                     drive_low <= ~reg_rdata[7];
                     state     <= RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (slave) that answers an I2C master on a shared open-drain bus.
- Decodes START/STOP, matches a 7-bit address, and ACKs.
- Maps bus transfers onto a simple register-port interface: write-pointer byte, then auto-incrementing data writes/reads.
- Sits on the fabric side of the bus, serving a user register bank; system clk is far faster than SCL (100 MHz vs 400 kHz).

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address this target responds to.
- NUM_REGS, 16, number of 8-bit registers addressable; power of 2, 2..256.
- ADDR_W, $clog2(NUM_REGS), register pointer width (derived, do not override).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from master (no clock stretching).
- sda  inout  1  I2C data, open-drain: driven 0 or released to Z.
- reg_addr  output  ADDR_W  current register pointer.
- reg_wdata  output  8  write data, valid while reg_we=1.
- reg_we  output  1  one-clk write strobe.
- reg_rdata  input  8  combinational read data for reg_addr from user bank.
- busy  output  1  high from address match until STOP / mismatch / NACK-end.
- stop_det  output  1  one-clk pulse on every detected STOP.

Behaviour:
- Reset (reset=0, async): sda released (Z), reg_addr=0, reg_wdata=0, reg_we=0, busy=0, stop_det=0, FSM=IDLE, bit counter=0.
- scl/sda each pass through a 2-flop synchronizer plus a previous-value flop. Edges are detected on synchronized values, giving 3-clk latency.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are detected in any state.
  - START (incl. repeated) -> ADDR, bit count 0.
  - STOP -> IDLE, release sda, busy=0, stop_det pulses 1 clk.
- Sampling: sample sda on scl rising edge. Change driven sda only on scl falling edge. Bits are MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, WDATA, W_ACK, RDATA, R_ACK, WAIT_STOP.
- ADDR: shift 8 bits.
  - If byte[7:1]==SLAVE_ADDR: on next scl fall drive sda=0 (ACK), busy=1, go ADDR_ACK; latch R/W=byte[0].
  - Otherwise go WAIT_STOP with sda released. NACK is by omission.
- ADDR_ACK: on following scl fall release ACK.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA: load shift reg with reg_rdata and drive MSB on that same fall.
- PTR: after 8 bits, reg_addr <= byte[ADDR_W-1:0] (upper bits ignored); ACK via W_ACK; then WDATA.
- WDATA: after 8th rising-edge sample, on the scl fall that starts ACK:
  - reg_wdata=byte and reg_we=1 for exactly 1 clk at current reg_addr; drive ACK.
  - reg_addr increments one clk later, modulo NUM_REGS (NUM_REGS-1 wraps to 0).
  - Unlimited bytes until STOP/START.
- RDATA: shift out 8 bits; release sda on the 8th fall for master ACK; sample in R_ACK on rise.
  - ACK (0): reg_addr++ (wrap); next fall loads reg_rdata and drives MSB.
  - NACK (1): WAIT_STOP, sda released, busy=0.
- WAIT_STOP: ignore bus until START or STOP.
- reg_addr persists across transactions, so write-pointer + repeated-START read works.
- START and STOP take priority over bit processing in the same clk.
- A START mid-byte aborts the byte: no reg_we is issued and reg_addr is unchanged.
- Driving rule: sda = drive_low ? 1'b0 : 1'bz. The block never drives 1.

Test Plan:
- Write 0x84 (addr 0x42, W), 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg_we pulses with (reg_addr,reg_wdata)=(3,0xA5) then (4,0x5A); stop_det pulses; final reg_addr=5.
- Write 0x84, 0x02, repeated START, 0x85, master ACKs 1 byte then NACKs, user bank returns reg[2]=0x11, reg[3]=0x22 -> bus reads 0x11, 0x22; reg_addr=3 after; sda released after NACK; busy=0.
- Address 0x86 (addr 0x43) -> no ACK (sda stays high on 9th clock); busy stays 0; no reg_we until next START.
- Write 0x84, 0x0F, 0xAA, 0xBB with NUM_REGS=16 -> writes at 15 then 0; reg_addr wraps to 1.
- reset low during RDATA with sda driven low -> sda immediately Z, all outputs 0; next full write transaction works normally.
- Pointer byte 0xF3 with NUM_REGS=16 -> reg_addr=3. Master issues START after 4 data bits -> no reg_we; FSM in ADDR.
